// File: rtl/hamming_seq_ctrl.sv
// Job sequencer for Hamming(16,11) SECDED: walks NUM_MSG messages through the
// single-port data memory, encoding or decoding each one and writing it back.
module hamming_seq_ctrl #(
    parameter int NUM_MSG = 15,
    parameter int AW      = 8,
    parameter int ENC_SRC = 0,
    parameter int ENC_DST = 30,
    parameter int DEC_SRC = 64,
    parameter int DEC_DST = 94
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req,
    input  logic          mode,
    output logic          ack,
    output logic          busy,
    output logic [AW-1:0] mem_addr,
    input  logic [7:0]    mem_rd_data,
    output logic [7:0]    mem_wr_data,
    output logic          mem_wr_en,
    output logic [3:0]    n_single,
    output logic [3:0]    n_double
);

    localparam int IW = (NUM_MSG > 1) ? $clog2(NUM_MSG) : 1;

    typedef enum logic [2:0] {IDLE, RD_LO, RD_HI, WR_LO, WR_HI, DONE} state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] i_q, i_d;
    logic          mode_q, mode_d;
    logic [7:0]    lo_q, lo_d;
    logic [7:0]    hi_q, hi_d;
    logic [3:0]    n_single_q, n_single_d;
    logic [3:0]    n_double_q, n_double_d;

    // Encoder: d[11:1] maps to ds[10:0]
    logic [10:0] ds;
    logic        p8, p4, p2, p1, p0;
    logic [15:0] enc_w;

    assign ds    = {hi_q[2:0], lo_q};
    assign p8    = ^ds[10:4];
    assign p4    = (^ds[10:7]) ^ (^ds[3:1]);
    assign p2    = ds[10] ^ ds[9] ^ ds[6] ^ ds[5] ^ ds[3] ^ ds[2] ^ ds[0];
    assign p1    = ds[10] ^ ds[8] ^ ds[6] ^ ds[4] ^ ds[3] ^ ds[1] ^ ds[0];
    assign p0    = (^ds) ^ p8 ^ p4 ^ p2 ^ p1;
    assign enc_w = {ds[10:4], p8, ds[3:1], p4, ds[0], p2, p1, p0};

    // Decoder: odd overall parity means a correctable single error at w[syn]
    logic [15:0] raw_w, fixed_w, dec_w;
    logic [3:0]  syn;
    logic        par, dbl;

    assign raw_w = {hi_q, lo_q};

    always_comb begin
        syn = '0;
        for (int k = 1; k < 16; k++) begin
            if (raw_w[k]) syn = syn ^ 4'(k);
        end
    end

    assign par     = ^raw_w;
    assign dbl     = !par && (syn != 4'd0);
    assign fixed_w = par ? (raw_w ^ (16'd1 << syn)) : raw_w;
    assign dec_w   = {dbl, 4'b0000, fixed_w[15:9], fixed_w[7:5], fixed_w[3]};

    logic [15:0]   result;
    logic [AW-1:0] src_base, dst_base, off;

    assign result   = mode_q ? dec_w : enc_w;
    assign src_base = mode_q ? AW'(DEC_SRC) : AW'(ENC_SRC);
    assign dst_base = mode_q ? AW'(DEC_DST) : AW'(ENC_DST);
    assign off      = AW'({i_q, 1'b0});

    always_comb begin
        state_d     = state_q;
        i_d         = i_q;
        mode_d      = mode_q;
        lo_d        = lo_q;
        hi_d        = hi_q;
        n_single_d  = n_single_q;
        n_double_d  = n_double_q;
        mem_addr    = '0;
        mem_wr_en   = 1'b0;
        mem_wr_data = 8'h00;
        ack         = 1'b0;
        busy        = 1'b1;
        case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (req) begin
                    mode_d     = mode;
                    i_d        = '0;
                    n_single_d = 4'd0;
                    n_double_d = 4'd0;
                    state_d    = RD_LO;
                end
            end
            RD_LO: begin
                mem_addr = src_base + off;
                lo_d     = mem_rd_data;
                state_d  = RD_HI;
            end
            RD_HI: begin
                mem_addr = src_base + off + AW'(1);
                hi_d     = mem_rd_data;
                state_d  = WR_LO;
            end
            WR_LO: begin
                mem_addr    = dst_base + off;
                mem_wr_en   = 1'b1;
                mem_wr_data = result[7:0];
                // Error statistics only make sense for decode jobs
                if (mode_q && par && (n_single_q != 4'hF)) n_single_d = n_single_q + 4'd1;
                if (mode_q && dbl && (n_double_q != 4'hF)) n_double_d = n_double_q + 4'd1;
                state_d = WR_HI;
            end
            WR_HI: begin
                mem_addr    = dst_base + off + AW'(1);
                mem_wr_en   = 1'b1;
                mem_wr_data = result[15:8];
                if (i_q == IW'(NUM_MSG - 1)) begin
                    state_d = DONE;
                end else begin
                    i_d     = i_q + IW'(1);
                    state_d = RD_LO;
                end
            end
            DONE: begin
                ack     = 1'b1;
                state_d = IDLE;
            end
            default: begin
                busy    = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            i_q        <= '0;
            mode_q     <= 1'b0;
            lo_q       <= 8'h00;
            hi_q       <= 8'h00;
            n_single_q <= 4'd0;
            n_double_q <= 4'd0;
        end else begin
            state_q    <= state_d;
            i_q        <= i_d;
            mode_q     <= mode_d;
            lo_q       <= lo_d;
            hi_q       <= hi_d;
            n_single_q <= n_single_d;
            n_double_q <= n_double_d;
        end
    end

    assign n_single = n_single_q;
    assign n_double = n_double_q;

endmodule

// File: doc/hamming_seq_ctrl.md
Name: hamming_seq_ctrl

Overview:
- Hardware sequencer for the Hamming(16,11) SECDED jobs: on a req pulse, walks NUM_MSG messages in data memory, encodes or decodes each one, writes results back, then pulses ack.
- Sits between the top-level req/ack handshake and the single-port data memory.
- Owns the memory port for the whole job.

Parameters:
NUM_MSG, 15, messages per job
AW, 8, memory address width
ENC_SRC, 0, encode source base byte address
ENC_DST, 30, encode destination base
DEC_SRC, 64, decode source base
DEC_DST, 94, decode destination base

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
req  in  1  start request, sampled only in IDLE
mode  in  1  0 = encode, 1 = decode; latched with req
ack  out  1  one-cycle job-done pulse
busy  out  1  high from accept until ack cycle inclusive
mem_addr  out  AW  byte address
mem_rd_data  in  8  combinational read data for mem_addr
mem_wr_data  out  8  write data
mem_wr_en  out  1  write strobe, memory writes on rising clk
n_single  out  4  single errors corrected this job (saturating)
n_double  out  4  double errors detected this job (saturating)

Behaviour:
- Reset (reset==0, asynchronous):
  - state IDLE; index i=0.
  - ack, busy, mem_wr_en, mem_addr, mem_wr_data, n_single, n_double all 0.
- Word layout, w[15:0]: {d11..d5, p8, d4..d2, p4, d1, p2, p1, p0}.
  - w[k] for k=1..15 is Hamming position k.
  - Message i is stored with its low byte at base+2i and high byte at base+2i+1.
- Encode source: lo = d[8:1], hi = {5'b0, d[11:9]}; hi[7:3] ignored.
  - p8 = ^d[11:5]
  - p4 = ^d[11:8] ^ ^d[4:2]
  - p2 = d11^d10^d7^d6^d4^d3^d1
  - p1 = d11^d9^d7^d5^d4^d2^d1
  - p0 = ^d ^ p8^p4^p2^p1
- Decode: syndrome s = XOR of k over all k in 1..15 with w[k]=1 (4 bits); P = ^w.
  - P=1: single error; flip w[s] (s=0 means p0 flipped); n_single++.
  - P=0, s!=0: double error; no correction; n_double++.
  - P=0, s=0: clean word.
  - Output is {dbl, 4'b0, d[11:1]}, with d extracted from the (corrected) w and dbl = double-error flag.
- FSM states: IDLE, RD_LO, RD_HI, WR_LO, WR_HI, DONE.
  - IDLE: req=1 at a clock edge latches mode, clears i, n_single and n_double, and moves to RD_LO.
  - RD_LO: mem_addr = src+2i; capture mem_rd_data as lo.
  - RD_HI: mem_addr = src+2i+1; capture hi.
  - WR_LO: mem_addr = dst+2i; mem_wr_en=1; mem_wr_data = result[7:0]. Counters update on this edge.
  - WR_HI: mem_addr = dst+2i+1; mem_wr_en=1; mem_wr_data = result[15:8].
  - WR_HI transitions: if i==NUM_MSG-1 go to DONE, else i++ and go to RD_LO.
  - DONE: ack=1, busy=1 for exactly one cycle, then IDLE.
- Timing:
  - 4 cycles per message.
  - ack is high in the cycle starting 4*NUM_MSG edges after the accept edge (60 for the default NUM_MSG).
  - A back-to-back req is accepted no earlier than the edge after DONE.
- Outputs mem_wr_en, mem_addr and ack are decoded from registered state only; no combinational path from req.
- req while busy (including the DONE cycle) is ignored; no queuing.
- mode changes after accept have no effect.
- Address arithmetic is mod 2^AW; wrap is not flagged.
- Counters saturate at 15.
- Reset mid-job:
  - Immediately deasserts mem_wr_en; FSM returns to IDLE.
  - No ack is produced.
  - Bytes already written remain in memory.
- src and dst regions may overlap. Each source message is read in full before its result is written.

Test Plan:
- Encode, memory 0/1 = 8'h00/8'h00 -> bytes 30/31 = 8'h00/8'h00; ack exactly 60 edges after accept; n_single=n_double=0.
- Encode d=11'h7FF (8'hFF, 8'h07) -> 16'hFFFF. Encode d=11'h001 (8'h01, 8'h00) -> 16'h000F. Bits 7:3 of the high source byte set to 1 do not change either result.
- Decode: 16'h0007 (bit3 flipped) -> 16'h0001, n_single=1. 16'h0001 (p0 flipped) -> 16'h0000, n_single=1. 16'h0000 -> 16'h0000, counters 0.
- Decode 16'h0006 (two flips) -> 16'h8000, n_double=1. 15 double-error words -> n_double=15 (saturated).
- req re-pulsed during cycle 10 of a job -> ignored; exactly one ack. mode toggled mid-job -> results follow the latched mode.
- reset asserted during a WR_LO cycle -> mem_wr_en=0 immediately, busy=0, no ack. A following req runs a full clean job with correct results.
